// File: rtl/ffs_bit_iter_m.sv
// ffs_bit_iter_m: drains a bit-vector into a stream of set-bit indices.
// A vector is loaded through a valid/ready handshake into a mask. Each
// consumed output beat clears the reported bit. The block is scanning
// whenever the mask is non-zero.
// ffs_m is the find-first-set priority encoder used for the scan.

// ffs_m: combinational find-first-set.
// SIDE=0 reports the highest set index. SIDE=1 reports the lowest set index.
module ffs_m #(
  parameter int   WIDTH = 8,
  parameter logic SIDE  = 1'b0,
  localparam int  IW    = $clog2((WIDTH < 2) ? 2 : WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IW-1:0]    index,
  output logic             valid
);

  // Each loop lets the winning bit overwrite earlier candidates.
  // The loop direction therefore chooses which end has priority.
  always_comb begin
    index = '0;
    valid = |vec;
    if (SIDE == 1'b0) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) index = IW'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) index = IW'(i);
      end
    end
  end

endmodule

module ffs_bit_iter_m #(
  parameter int   INPUT_WIDTH = 8,
  parameter logic SIDE        = 1'b0,
  // Widths below 1 make no sense, so they collapse to a single-bit vector.
  localparam int  W_EFF       = (INPUT_WIDTH < 1) ? 1 : INPUT_WIDTH,
  localparam int  IW          = $clog2((W_EFF < 2) ? 2 : W_EFF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_EFF-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_index,
  output logic             out_last,
  output logic             busy
);

  // The only stored state is the mask. IDLE and SCAN are a decode of it.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  generate
    if (INPUT_WIDTH < 1) begin : g_width_clamp
      $warning("ffs_bit_iter_m: INPUT_WIDTH < 1, using a width of 1");
    end
  endgenerate

  logic [W_EFF-1:0] mask_reg;
  logic [W_EFF-1:0] mask_next;
  logic [W_EFF-1:0] clr_onehot;
  logic [IW-1:0]    ffs_index;
  logic             ffs_valid;
  logic             single_bit;
  logic             beat;
  logic             load;
  scan_state_e      state;

  ffs_m #(
    .WIDTH (W_EFF),
    .SIDE  (SIDE)
  ) u_ffs (
    .vec   (mask_reg),
    .index (ffs_index),
    .valid (ffs_valid)
  );

  // Build a one-hot mask of the bit that the current beat retires.
  generate
    for (genvar gi = 0; gi < W_EFF; gi++) begin : g_clr
      assign clr_onehot[gi] = (ffs_index == IW'(gi));
    end
  endgenerate

  // Decode the scan state and the handshake outputs from the mask.
  always_comb begin
    state      = ffs_valid ? ST_SCAN : ST_IDLE;
    // Clearing the lowest set bit leaves zero only for a one-hot mask.
    single_bit = ((mask_reg & (mask_reg - W_EFF'(1))) == '0);
    out_valid  = (state == ST_SCAN);
    out_index  = ffs_index;
    out_last   = out_valid & single_bit;
    busy       = out_valid;
    beat       = out_valid & out_ready;
    // The last beat frees the mask on the same edge, so a new vector can
    // load without a bubble. flush blocks acceptance so no vector is lost.
    in_ready   = !flush & ((state == ST_IDLE) | (beat & out_last));
    load       = in_valid & in_ready;
  end

  // Choose the next mask. flush wins, then a load, then the clear of the
  // consumed bit. A load replaces the mask on the edge of the last beat.
  always_comb begin
    mask_next = mask_reg;
    if (flush) begin
      mask_next = '0;
    end else if (load) begin
      mask_next = in_data;
    end else if (beat) begin
      mask_next = mask_reg & ~clr_onehot;
    end
  end

  // Mask register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_reg <= '0;
    end else begin
      mask_reg <= mask_next;
    end
  end

endmodule

// File: tb/tb_ffs_bit_iter_m.sv
// Directed bench for ffs_bit_iter_m.
// Main instance: W=8, SIDE=0. Extra instances: W=8/SIDE=1, W=5/SIDE=0, W=1.
// Inputs are driven on the falling edge. Outputs are checked 1ns later.
module tb_ffs_bit_iter_m;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       rst, flush;

  // main instance (W=8, SIDE=0)
  logic       in_valid, out_ready, in_ready, out_valid, out_last, busy;
  logic [7:0] in_data;
  logic [2:0] out_index;

  // SIDE=1 instance
  logic       s1_in_valid, s1_out_ready, s1_in_ready, s1_out_valid, s1_out_last, s1_busy;
  logic [7:0] s1_in_data;
  logic [2:0] s1_out_index;

  // W=5 instance
  logic       w5_in_valid, w5_out_ready, w5_in_ready, w5_out_valid, w5_out_last, w5_busy;
  logic [4:0] w5_in_data;
  logic [2:0] w5_out_index;

  // W=1 instance
  logic       w1_in_valid, w1_out_ready, w1_in_ready, w1_out_valid, w1_out_last, w1_busy;
  logic [0:0] w1_in_data;
  logic [0:0] w1_out_index;

  ffs_bit_iter_m #(.INPUT_WIDTH(8), .SIDE(1'b0)) u_main (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_last(out_last), .busy(busy)
  );

  ffs_bit_iter_m #(.INPUT_WIDTH(8), .SIDE(1'b1)) u_side1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_data(s1_in_data),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_index(s1_out_index),
    .out_last(s1_out_last), .busy(s1_busy)
  );

  ffs_bit_iter_m #(.INPUT_WIDTH(5), .SIDE(1'b0)) u_w5 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(w5_in_valid), .in_ready(w5_in_ready), .in_data(w5_in_data),
    .out_valid(w5_out_valid), .out_ready(w5_out_ready), .out_index(w5_out_index),
    .out_last(w5_out_last), .busy(w5_busy)
  );

  ffs_bit_iter_m #(.INPUT_WIDTH(1), .SIDE(1'b0)) u_w1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(w1_in_valid), .in_ready(w1_in_ready), .in_data(w1_in_data),
    .out_valid(w1_out_valid), .out_ready(w1_out_ready), .out_index(w1_out_index),
    .out_last(w1_out_last), .busy(w1_busy)
  );

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    s1_in_valid = 1'b0; s1_in_data = '0; s1_out_ready = 1'b1;
    w5_in_valid = 1'b0; w5_in_data = '0; w5_out_ready = 1'b1;
    w1_in_valid = 1'b0; w1_in_data = '0; w1_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready, out_last} !== 4'b0010) begin
      failures++;
      $display("FAIL reset_state: got valid/busy/ready/last=%b expected 0010",
               {out_valid, busy, in_ready, out_last});
    end
    checks++;
    if ({w1_out_valid, w1_busy, w1_in_ready, w1_out_last} !== 4'b0010) begin
      failures++;
      $display("FAIL reset_state_w1: got %b expected 0010",
               {w1_out_valid, w1_busy, w1_in_ready, w1_out_last});
    end
    // A zero vector is accepted and yields no beats.
    in_valid = 1'b1; in_data = 8'h00;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_vec_ready: got %b expected 1", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL zero_vec_nobeat: cycle %0d got valid=%b busy=%b expected 0 0",
                 c, out_valid, busy);
      end
    end
  endtask

  task automatic test_side0();
    int exp_idx[4] = '{7, 5, 2, 1};
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'b1010_0110; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL side0_accept: got in_ready=%b expected 1", in_ready);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_index !== 3'(exp_idx[b]) || out_last !== (b == 3)) begin
        failures++;
        $display("FAIL side0_beat%0d: got v=%b idx=%0d last=%b expected v=1 idx=%0d last=%b",
                 b, out_valid, out_index, out_last, exp_idx[b], (b == 3));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL side0_done: got valid=%b busy=%b expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_side1();
    int exp_idx[4] = '{1, 2, 5, 7};
    @(negedge clk);
    s1_in_valid = 1'b1; s1_in_data = 8'b1010_0110; s1_out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      s1_in_valid = 1'b0;
      #1;
      checks++;
      if (s1_out_valid !== 1'b1 || s1_out_index !== 3'(exp_idx[b]) || s1_out_last !== (b == 3)) begin
        failures++;
        $display("FAIL side1_beat%0d: got v=%b idx=%0d last=%b expected v=1 idx=%0d last=%b",
                 b, s1_out_valid, s1_out_index, s1_out_last, exp_idx[b], (b == 3));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (s1_out_valid !== 1'b0 || s1_busy !== 1'b0) begin
      failures++;
      $display("FAIL side1_done: got valid=%b busy=%b expected 0 0", s1_out_valid, s1_busy);
    end
  endtask

  // out_ready follows 1,0,0,1,... while 8'h81 is offered throughout the scan.
  task automatic test_backpressure();
    int exp_idx[10] = '{7, 5, 5, 5, 2, 2, 2, 1, 1, 1};
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'b1010_0110; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h81; out_ready = (c % 3 == 0);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_index !== 3'(exp_idx[c]) || out_last !== (c >= 7)
          || in_ready !== (c == 9)) begin
        failures++;
        $display("FAIL bp_cycle%0d: got v=%b idx=%0d last=%b rdy=%b expected v=1 idx=%0d last=%b rdy=%b",
                 c, out_valid, out_index, out_last, in_ready, exp_idx[c], (c >= 7), (c == 9));
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_index !== ((c == 0) ? 3'd7 : 3'd0) || out_last !== (c == 1)) begin
        failures++;
        $display("FAIL bp_second%0d: got v=%b idx=%0d last=%b expected v=1 idx=%0d last=%b",
                 c, out_valid, out_index, out_last, (c == 0) ? 7 : 0, (c == 1));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_done: got valid=%b expected 0", out_valid);
    end
  endtask

  // 8'h03 then 8'h80 with no bubble between them.
  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h03; out_ready = 1'b1;
    @(negedge clk);
    in_data = 8'h80;
    #1;
    checks++;
    if (out_index !== 3'd1 || out_last !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: got idx=%0d last=%b rdy=%b expected 1 0 0",
               out_index, out_last, in_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_index !== 3'd0 || out_last !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_last: got idx=%0d last=%b rdy=%b expected 0 1 1",
               out_index, out_last, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_index !== 3'd7 || out_last !== 1'b1) begin
      failures++;
      $display("FAIL b2b_next: got v=%b idx=%0d last=%b expected 1 7 1",
               out_valid, out_index, out_last);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_index !== 3'(7 - c)) begin
        failures++;
        $display("FAIL flush_pre%0d: got idx=%0d expected %0d", c, out_index, 7 - c);
      end
    end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h10;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready: got in_ready=%b expected 0", in_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_cleared: got v=%b busy=%b rdy=%b expected 0 0 1",
               out_valid, busy, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_index !== 3'd4 || out_last !== 1'b1) begin
      failures++;
      $display("FAIL flush_next: got v=%b idx=%0d last=%b expected 1 4 1",
               out_valid, out_index, out_last);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_done: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_odd_widths();
    @(negedge clk);
    w5_in_valid = 1'b1; w5_in_data = 5'b10001; w5_out_ready = 1'b1;
    w1_in_valid = 1'b1; w1_in_data = 1'b1;     w1_out_ready = 1'b1;
    @(negedge clk);
    w5_in_valid = 1'b0; w1_in_valid = 1'b0;
    #1;
    checks++;
    if (w5_out_valid !== 1'b1 || w5_out_index !== 3'd4 || w5_out_last !== 1'b0) begin
      failures++;
      $display("FAIL w5_beat0: got v=%b idx=%0d last=%b expected 1 4 0",
               w5_out_valid, w5_out_index, w5_out_last);
    end
    checks++;
    if (w1_out_valid !== 1'b1 || w1_out_index !== 1'b0 || w1_out_last !== 1'b1) begin
      failures++;
      $display("FAIL w1_beat: got v=%b idx=%0d last=%b expected 1 0 1",
               w1_out_valid, w1_out_index, w1_out_last);
    end
    @(negedge clk);
    #1;
    checks++;
    if (w5_out_valid !== 1'b1 || w5_out_index !== 3'd0 || w5_out_last !== 1'b1) begin
      failures++;
      $display("FAIL w5_beat1: got v=%b idx=%0d last=%b expected 1 0 1",
               w5_out_valid, w5_out_index, w5_out_last);
    end
    checks++;
    if (w1_out_valid !== 1'b0 || w1_busy !== 1'b0) begin
      failures++;
      $display("FAIL w1_done: got v=%b busy=%b expected 0 0", w1_out_valid, w1_busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (w5_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL w5_done: got valid=%b expected 0", w5_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_side0();
    test_side1();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_odd_widths();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
